iobus_gpio: RTL and testbench

Memory-mapped LED/button peripheral on the I/O bus, downstream of the I/O controller. Decodes a 4-register window, drives the 9 board LEDs from a writable register, and synchronises, debounces and edge-captures the 8 board buttons. Answers every decoded access with a single-cycle `ready` pulse over the shared tri-state `data` bus. Optionally raises a masked interrupt on captured button presses.

---
 rtl/iobus_gpio_pkg.sv | 10 +
 rtl/iobus_gpio_debounce.sv | 41 ++++
 rtl/iobus_gpio.sv | 92 +++++++++
 tb/tb_iobus_gpio.sv | 183 ++++++++++++++++++
 4 files changed

// File: rtl/iobus_gpio_pkg.sv
// iobus_gpio_pkg: register offsets, port widths and access-FSM states shared by iobus_gpio
package iobus_gpio_pkg;
   localparam logic [1:0] GPIO_REG_LED   = 2'd0;
   localparam logic [1:0] GPIO_REG_STATE = 2'd1;
   localparam logic [1:0] GPIO_REG_EDGE  = 2'd2;
   localparam logic [1:0] GPIO_REG_MASK  = 2'd3;
   localparam int GPIO_LED_W = 9;
   localparam int GPIO_BTN_W = 8;
   typedef enum logic [1:0] {ST_IDLE, ST_ACK, ST_WAIT} acc_state_e;
endpackage

// File: rtl/iobus_gpio_debounce.sv
// iobus_gpio_debounce: one button's 2-flop synchroniser, stability counter and debounced level
module iobus_gpio_debounce #(
   parameter int DEBOUNCE_CYCLES = 16
) (
   input  logic clk,
   input  logic rst_n,
   input  logic btn,
   output logic state,
   output logic rise
);
   localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
   logic sync1_q, sync2_q, state_q, state_d;
   logic [CW-1:0] cnt_q, cnt_d;
   always_comb begin
      state_d = state_q;
      cnt_d = '0;
      if (sync2_q != state_q) begin
         cnt_d = cnt_q + 1'b1;
         if (cnt_d == CW'(DEBOUNCE_CYCLES)) begin
            state_d = ~state_q;
            cnt_d = '0;
         end
      end
   end
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         sync1_q <= 1'b0;
         sync2_q <= 1'b0;
         state_q <= 1'b0;
         cnt_q <= '0;
      end else begin
         sync1_q <= btn;
         sync2_q <= sync1_q;
         state_q <= state_d;
         cnt_q <= cnt_d;
      end
   end
   assign state = state_q;
   // combinational so the edge flag sets on the same clock edge the level rises
   assign rise = state_d & ~state_q;
endmodule

// File: rtl/iobus_gpio.sv
// iobus_gpio: I/O-bus LED/button peripheral decoding a 4-register window with single-cycle ready.
// Define IOBUS_GPIO_IRQ_EN to build the button mask register and the masked edge interrupt.
module iobus_gpio
   import iobus_gpio_pkg::*;
#(
   parameter int ADDR_WIDTH = 8,
   parameter int DATA_WIDTH = 16,
   parameter logic [ADDR_WIDTH-1:0] BASE_ADDR = '0,
   parameter int DEBOUNCE_CYCLES = 16
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic [ADDR_WIDTH-1:0] addr,
   inout  wire  [DATA_WIDTH-1:0] data,
   input  logic                  read,
   input  logic                  write,
   output logic                  ready,
   output logic [GPIO_LED_W-1:0] leds,
   input  logic [GPIO_BTN_W-1:0] buttons,
   output logic                  irq
);
   acc_state_e st_q, st_d;
   logic ready_q, ready_d, drive_q, drive_d;
   logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
   logic [GPIO_LED_W-1:0] led_q, led_d, rsel;
   logic [GPIO_BTN_W-1:0] edge_q, edge_d, btn_state, btn_rise, mask_v;
   logic [1:0] off;
   logic hit, acc, wr, unused_data;
   assign off = addr[1:0];
   assign hit = addr[ADDR_WIDTH-1:2] == BASE_ADDR[ADDR_WIDTH-1:2];
   assign acc = st_q == ST_IDLE && hit && (read || write);
   assign wr = acc && write;
   assign unused_data = ^data;
   for (genvar i = 0; i < GPIO_BTN_W; i++) begin : g_btn
      iobus_gpio_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_deb (
         .clk(clk), .rst_n(rst_n), .btn(buttons[i]), .state(btn_state[i]), .rise(btn_rise[i])
      );
   end
   always_comb begin
      rsel = off == GPIO_REG_LED ? led_q :
             {1'b0, off == GPIO_REG_STATE ? btn_state : off == GPIO_REG_EDGE ? edge_q : mask_v};
      rdata_d = DATA_WIDTH'(rsel);
      led_d = (wr && off == GPIO_REG_LED) ? data[GPIO_LED_W-1:0] : led_q;
      edge_d = (edge_q & ~((wr && off == GPIO_REG_EDGE) ? data[GPIO_BTN_W-1:0] : '0)) | btn_rise;
      ready_d = acc;
      // a combined read+write strobe is a write, so the bus is left to the master
      drive_d = acc && !write;
      st_d = acc ? ST_ACK : (st_q == ST_IDLE || !(read || write)) ? ST_IDLE : ST_WAIT;
   end
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         st_q <= ST_IDLE;
         ready_q <= 1'b0;
         drive_q <= 1'b0;
         rdata_q <= '0;
         led_q <= '0;
         edge_q <= '0;
      end else begin
         st_q <= st_d;
         ready_q <= ready_d;
         drive_q <= drive_d;
         rdata_q <= rdata_d;
         led_q <= led_d;
         edge_q <= edge_d;
      end
   end
`ifdef IOBUS_GPIO_IRQ_EN
   logic [GPIO_BTN_W-1:0] mask_q, mask_d;
   logic irq_q, irq_d;
   always_comb begin
      mask_d = (wr && off == GPIO_REG_MASK) ? data[GPIO_BTN_W-1:0] : mask_q;
      irq_d = |(edge_q & mask_q);
   end
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         mask_q <= '0;
         irq_q <= 1'b0;
      end else begin
         mask_q <= mask_d;
         irq_q <= irq_d;
      end
   end
   assign mask_v = mask_q;
   assign irq = irq_q;
`else
   assign mask_v = '0;
   assign irq = 1'b0;
`endif
   assign data = drive_q ? rdata_q : 'z;
   assign ready = ready_q;
   assign leds = led_q;
endmodule

// File: tb/tb_iobus_gpio.sv
// tb_iobus_gpio: random bus and button stimulus checked against a behavioural register/debounce model
module tb_iobus_gpio;
   localparam int D = 16;
   localparam logic [7:0] BASE = 8'h40;
   logic clk = 1'b0, rst_n = 1'b0, rd = 1'b0, wr = 1'b0, tb_oe = 1'b0;
   logic [7:0] addr = '0, buttons = '0;
   logic [15:0] tb_val = '0;
   wire  [15:0] data;
   logic ready, irq;
   logic [8:0] leds;
   assign data = tb_oe ? tb_val : 'z;
   iobus_gpio #(.ADDR_WIDTH(8), .DATA_WIDTH(16), .BASE_ADDR(BASE), .DEBOUNCE_CYCLES(D)) dut (
      .clk(clk), .rst_n(rst_n), .addr(addr), .data(data), .read(rd), .write(wr),
      .ready(ready), .leds(leds), .buttons(buttons), .irq(irq)
   );
   always #5 clk = ~clk;
   int n_cmp = 0, n_bad = 0;
   task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
      end
   endtask
   logic [8:0] m_led = '0;
   logic [7:0] m_state = '0, m_edge = '0, m_mask = '0;
   logic m_irq = 1'b0;
   logic [7:0] hist [D+2];
   logic pend = 1'b0;
   logic [1:0] pend_off = '0;
   logic [15:0] pend_dat = '0;
   bit mon = 1'b0;
   // a button level flips once the D samples seen after the 2-stage sync delay all disagree with it
   always @(posedge clk) begin
      logic [7:0] ns, clr;
      logic flip;
      if (!rst_n) begin
         m_led = '0; m_state = '0; m_edge = '0; m_mask = '0; m_irq = 1'b0; pend = 1'b0;
         for (int j = 0; j < D + 2; j++) hist[j] = '0;
      end else begin
         for (int j = D + 1; j > 0; j--) hist[j] = hist[j-1];
         hist[0] = buttons;
         ns = m_state;
         for (int b = 0; b < 8; b++) begin
            flip = 1'b1;
            for (int j = 2; j < D + 2; j++) if (hist[j][b] == m_state[b]) flip = 1'b0;
            if (flip) ns[b] = ~m_state[b];
         end
         clr = '0;
`ifdef IOBUS_GPIO_IRQ_EN
         m_irq = |(m_edge & m_mask);
         if (pend && pend_off == 2'd3) m_mask = pend_dat[7:0];
`endif
         if (pend && pend_off == 2'd0) m_led = pend_dat[8:0];
         if (pend && pend_off == 2'd2) clr = pend_dat[7:0];
         m_edge = (m_edge & ~clr) | (ns & ~m_state);
         m_state = ns;
         pend = 1'b0;
      end
   end
   always @(negedge clk) if (mon) begin
      check("leds", 16'(leds), 16'(m_led));
      check("irq", 16'(irq), 16'(m_irq));
   end
   function automatic logic [15:0] m_read(input logic [1:0] o);
      return o == 2'd0 ? {7'b0, m_led} : o == 2'd1 ? {8'b0, m_state} : o == 2'd2 ? {8'b0, m_edge} : {8'b0, m_mask};
   endfunction
   function automatic logic [7:0] ra(input int o);
      return BASE | 8'(o);
   endfunction
   task automatic bus(input logic r, input logic w, input logic [7:0] a, input logic [15:0] wd,
                      input int hold, output logic [15:0] rdv);
      logic h;
      logic [15:0] exp;
      int nr;
      h = a[7:2] == BASE[7:2];
      nr = 0;
      rdv = '0;
      @(negedge clk);
      exp = m_read(a[1:0]);
      addr = a; rd = r; wr = w; tb_oe = w; tb_val = wd;
      if (h && w) begin pend = 1'b1; pend_off = a[1:0]; pend_dat = wd; end
      for (int i = 0; i < hold; i++) begin
         @(posedge clk); #1;
         if (i == 0) begin
            check("ack_lat", 16'(ready), 16'(h));
            if (h && w && a[1:0] == 2'd0) check("led_now", 16'(leds), 16'(wd[8:0]));
         end
         if (ready) begin nr++; rdv = data; end
      end
      @(negedge clk);
      rd = 1'b0; wr = 1'b0; tb_oe = 1'b0;
      repeat (2) begin
         @(posedge clk); #1;
         if (ready) nr++;
      end
      check("ack_cnt", 16'(nr), 16'(h));
      if (h && r && !w) check("rdata", rdv, exp);
      if (h && r && w) check("rw_data", rdv, wd);
   endtask
   initial begin
      logic [15:0] v;
      repeat (3) @(posedge clk);
      @(negedge clk);
      mon = 1'b1;
      rst_n = 1'b1;
      for (int o = 0; o < 4; o++) begin
         bus(1'b1, 1'b0, ra(o), 16'h0, 1, v);
         check("rst_reg", v, 16'h0);
      end
      bus(1'b0, 1'b1, ra(0), 16'h01A5, 1, v);
      bus(1'b1, 1'b0, ra(0), 16'h0, 1, v);
      check("led_rb", v, 16'h01A5);
      bus(1'b0, 1'b1, ra(0), 16'hFFFF, 1, v);
      bus(1'b1, 1'b0, ra(0), 16'h0, 1, v);
      check("led_ffff", v, 16'h01FF);
      @(negedge clk); buttons = 8'h04;
      repeat (16) @(posedge clk);
      bus(1'b1, 1'b0, ra(1), 16'h0, 1, v);
      check("state_early", v, 16'h0000);
      bus(1'b1, 1'b0, ra(1), 16'h0, 1, v);
      check("state_late", v, 16'h0004);
      @(negedge clk); buttons = 8'h05;
      repeat (10) @(posedge clk);
      @(negedge clk); buttons = 8'h04;
      repeat (30) @(posedge clk);
      bus(1'b1, 1'b0, ra(1), 16'h0, 1, v);
      check("glitch", v, 16'h0004);
      bus(1'b1, 1'b0, ra(2), 16'h0, 1, v);
      check("edge_set", v, 16'h0004);
      bus(1'b0, 1'b1, ra(2), 16'h0004, 1, v);
      bus(1'b1, 1'b0, ra(2), 16'h0, 1, v);
      check("edge_w1c", v, 16'h0000);
      @(negedge clk); buttons = 8'h00;
      repeat (30) @(posedge clk);
      @(negedge clk); buttons = 8'h04;
      repeat (17) @(posedge clk);
      bus(1'b0, 1'b1, ra(2), 16'h0004, 1, v);
      bus(1'b1, 1'b0, ra(2), 16'h0, 1, v);
      check("edge_race", v, 16'h0004);
`ifdef IOBUS_GPIO_IRQ_EN
      bus(1'b0, 1'b1, ra(3), 16'h0004, 1, v);
      check("irq_on", 16'(irq), 16'h1);
      bus(1'b0, 1'b1, ra(2), 16'h0004, 1, v);
      check("irq_off", 16'(irq), 16'h0);
`else
      bus(1'b0, 1'b1, ra(3), 16'h00FF, 1, v);
      bus(1'b1, 1'b0, ra(3), 16'h0, 1, v);
      check("mask_absent", v, 16'h0);
      check("irq_tied", 16'(irq), 16'h0);
`endif
      bus(1'b1, 1'b0, ra(0), 16'h0, 5, v);
      bus(1'b1, 1'b1, ra(0), 16'h0033, 1, v);
      bus(1'b1, 1'b0, ra(0), 16'h0, 1, v);
      check("rw_is_write", v, 16'h0033);
      bus(1'b1, 1'b0, BASE + 8'h04, 16'h0, 20, v);
      bus(1'b0, 1'b1, BASE + 8'h04, 16'h00AA, 1, v);
      for (int k = 0; k < 80; k++) begin
         case ($urandom_range(0, 4))
            0: bus(1'b0, 1'b1, ra(int'($urandom_range(0, 3))), 16'($urandom), 1, v);
            1: bus(1'b1, 1'b0, ra(int'($urandom_range(0, 3))), 16'h0, int'($urandom_range(1, 4)), v);
            2: begin
               @(negedge clk); buttons = 8'($urandom);
               repeat ($urandom_range(1, 40)) @(posedge clk);
            end
            3: bus(1'b0, 1'b1, ra(2), 16'($urandom), 1, v);
            default: bus(1'b1, 1'b0, ra(int'($urandom_range(1, 2))), 16'h0, 1, v);
         endcase
      end
      @(negedge clk); addr = ra(0); rd = 1'b1;
      @(posedge clk); #1;
      check("rst_ack_pre", 16'(ready), 16'h1);
      @(negedge clk); rst_n = 1'b0; rd = 1'b0;
      @(posedge clk); #1;
      check("rst_ack", 16'(ready), 16'h0);
      check("rst_leds", 16'(leds), 16'h0);
      @(negedge clk); rst_n = 1'b1;
      repeat (40) @(posedge clk);
      for (int o = 0; o < 4; o++) bus(1'b1, 1'b0, ra(o), 16'h0, 1, v);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
